// File: rtl/sseg_pkg.sv
// Shared constants and types for the 7-segment display path: glyphs, blank
// codes and the registered display word used by the scan driver.
package sseg_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SSEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Glyphs, gfedcba, active low
  localparam logic [6:0] SSEG_0    = 7'b1000000;
  localparam logic [6:0] SSEG_1    = 7'b1111001;
  localparam logic [6:0] SSEG_2    = 7'b0100100;
  localparam logic [6:0] SSEG_3    = 7'b0110000;
  localparam logic [6:0] SSEG_4    = 7'b0011001;
  localparam logic [6:0] SSEG_5    = 7'b0010010;
  localparam logic [6:0] SSEG_6    = 7'b0000010;
  localparam logic [6:0] SSEG_7    = 7'b1111000;
  localparam logic [6:0] SSEG_8    = 7'b0000000;
  localparam logic [6:0] SSEG_9    = 7'b0010000;
  localparam logic [6:0] SSEG_P    = 7'b0001100;
  localparam logic [6:0] SSEG_DASH = 7'b0111111;

  typedef logic [1:0] dig_idx_t;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, sseg: SSEG_BLANK, dp: 1'b1};

  function automatic logic [3:0] an_sel(input dig_idx_t idx);
    logic [3:0] a;
    a      = AN_OFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Slot/digit sequencer for the display scan: slot counter, digit index,
// frame counter and blink phase, exposed as decoded strobes.
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int SLOT_CYC     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic         clk,
  input  logic         rst,
  output dig_idx_t     idx,
  output logic         in_blank,
  output logic         snap,
  output blink_phase_t phase
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam dig_idx_t         IDX_LAST  = dig_idx_t'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt, cnt_nx;
  dig_idx_t         idx_nx;
  logic [FRM_W-1:0] frm, frm_nx;
  blink_phase_t     phase_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      frm   <= '0;
      phase <= PH_VISIBLE;
    end else begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      frm   <= frm_nx;
      phase <= phase_nx;
    end
  end

  // Frame counting only advances when the last digit's slot wraps to digit 0
  always_comb begin
    cnt_nx   = cnt + CNT_W'(1);
    idx_nx   = idx;
    frm_nx   = frm;
    phase_nx = phase;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = idx + dig_idx_t'(1);
      if (idx == IDX_LAST) begin
        if (frm == FRM_LAST) begin
          frm_nx   = '0;
          phase_nx = (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
        end else begin
          frm_nx = frm + FRM_W'(1);
        end
      end
    end
  end

  assign in_blank = (cnt < BLANK_LIM);
  assign snap     = (cnt == '0) && (idx == '0);

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame
// input snapshot, inter-digit blanking gap and per-digit blinking.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int SLOT_CYC     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] dig0,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  input  logic [3:0] dp_in,
  input  logic [3:0] blink,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic       dp
);

  if (SLOT_CYC < 2) begin : g_bad_slot
    $error("sseg_scan: SLOT_CYC must be >= 2");
  end
  if (BLANK_CYC >= SLOT_CYC) begin : g_bad_blank
    $error("sseg_scan: BLANK_CYC must be < SLOT_CYC");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("sseg_scan: BLINK_FRAMES must be >= 1");
  end

  dig_idx_t     idx;
  logic         in_blank;
  logic         snap;
  blink_phase_t phase;

  sseg_scan_timer #(
    .SLOT_CYC    (SLOT_CYC),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .idx     (idx),
    .in_blank(in_blank),
    .snap    (snap),
    .phase   (phase)
  );

  // Shadow copy keeps one frame coherent even if the converters change mid-scan
  logic [6:0] sh_dig [N_DIGITS];
  logic [3:0] sh_dp;
  logic [3:0] sh_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_DIGITS; k++) sh_dig[k] <= SSEG_BLANK;
      sh_dp    <= '1;
      sh_blink <= '0;
    end else if (snap) begin
      sh_dig[0] <= dig0;
      sh_dig[1] <= dig1;
      sh_dig[2] <= dig2;
      sh_dig[3] <= dig3;
      sh_dp     <= dp_in;
      sh_blink  <= blink;
    end
  end

  // Stage p0: select the digit for the current slot, or blank
  disp_t out_p0;
  logic  blank_p0;

  always_comb begin
    blank_p0 = in_blank || !en || (sh_blink[idx] && (phase == PH_HIDDEN));
    out_p0   = DISP_OFF;
    if (!blank_p0) begin
      out_p0 = '{an: an_sel(idx), sseg: sh_dig[idx], dp: sh_dp[idx]};
    end
  end

  // Stage p1: registered pins
  disp_t out_p1;

  always_ff @(posedge clk) begin
    if (rst) out_p1 <= DISP_OFF;
    else     out_p1 <= out_p0;
  end

  assign an   = out_p1.an;
  assign sseg = out_p1.sseg;
  assign dp   = out_p1.dp;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: per-cycle scoreboard against a behavioural model plus
// closed-form and table expectations for scan, snapshot, blink, enable, reset.
module tb_sseg_scan;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] dig0 = '1, dig1 = '1, dig2 = '1, dig3 = '1;
  logic [3:0] dp_in = '1, blink = '0;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;

  sseg_scan #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en(en),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .blink(blink),
    .an(an), .sseg(sseg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
  } obs_t;

  localparam obs_t OFF = '{an: 4'b1111, sseg: 7'b1111111, dp: 1'b1};

  typedef struct {
    logic [6:0] dig;
    logic       dpb;
    logic [3:0] an;
  } vec_t;

  typedef struct {
    int   lo;
    int   hi;
    obs_t o;
  } rseg_t;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t sbq[$];

  // Behavioural reference state
  int         m_cnt = 0, m_idx = 0, m_frm = 0;
  logic       m_hid = 1'b0;
  logic [6:0] m_dig [4];
  logic [3:0] m_dp  = '1;
  logic [3:0] m_blk = '0;

  function automatic obs_t cur();
    return '{an: an, sseg: sseg, dp: dp};
  endfunction

  task automatic chk(input string name, input obs_t g, input obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got an=%b sseg=%b dp=%b, want an=%b sseg=%b dp=%b",
               name, g.an, g.sseg, g.dp, e.an, e.sseg, e.dp);
    end
  endtask

  // One clock: predict, push, advance model, wait edge, pop and compare
  task automatic tick();
    obs_t       e;
    obs_t       g;
    logic [3:0] one = 4'b0001;
    e = OFF;
    if (!rst && m_cnt >= BLANK && en && !(m_blk[m_idx] && m_hid))
      e = '{an: ~(one << m_idx), sseg: m_dig[m_idx], dp: m_dp[m_idx]};
    sbq.push_back(e);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_frm = 0; m_hid = 1'b0;
      for (int k = 0; k < 4; k++) m_dig[k] = 7'b1111111;
      m_dp = '1; m_blk = '0;
    end else begin
      if (m_cnt == 0 && m_idx == 0) begin
        m_dig[0] = dig0; m_dig[1] = dig1; m_dig[2] = dig2; m_dig[3] = dig3;
        m_dp = dp_in; m_blk = blink;
      end
      if (m_cnt == SLOT - 1) begin
        m_cnt = 0;
        if (m_idx == 3) begin
          m_idx = 0;
          if (m_frm == BF - 1) begin m_frm = 0; m_hid = ~m_hid; end
          else m_frm++;
        end else m_idx++;
      end else m_cnt++;
    end
    @(posedge clk);
    #1;
    g = cur();
    e = sbq.pop_front();
    chk("scoreboard", g, e);
    n_cmp++;
    if ($countones(~an) > 1) begin
      n_err++;
      $display("FAIL one_anode: got an=%b, want at most one low bit", an);
    end
  endtask

  vec_t  tab [4];
  rseg_t rs  [4];

  initial begin
    obs_t e;
    int   c, s, f;
    logic hidden;

    for (int k = 0; k < 4; k++) m_dig[k] = 7'b1111111;

    tab[0] = '{dig: 7'b1000000, dpb: 1'b0, an: 4'b1110};
    tab[1] = '{dig: 7'b1111001, dpb: 1'b1, an: 4'b1101};
    tab[2] = '{dig: 7'b0100100, dpb: 1'b1, an: 4'b1011};
    tab[3] = '{dig: 7'b0110000, dpb: 1'b1, an: 4'b0111};

    // Reset held with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); dig0 = 7'($urandom); dig1 = 7'($urandom);
      dig2 = 7'($urandom); dig3 = 7'($urandom);
      dp_in = 4'($urandom); blink = 4'($urandom);
      tick();
      chk($sformatf("reset c%0d", i), cur(), OFF);
    end

    // Release; blink on digit 0 from the first frame
    rst = 1'b0; en = 1'b1;
    dig0 = tab[0].dig; dig1 = tab[1].dig; dig2 = tab[2].dig; dig3 = tab[3].dig;
    dp_in = {tab[3].dpb, tab[2].dpb, tab[1].dpb, tab[0].dpb};
    blink = 4'b0001;

    for (int gt = 0; gt < 8 * FRAME + 3 * SLOT + 3; gt++) begin
      if (gt == 20)  dig1 = 7'b0001100;
      if (gt == 36)  dig1 = 7'b0010010;
      if (gt == 212) en = 1'b0;
      if (gt == 232) en = 1'b1;
      c = gt % SLOT;
      s = (gt / SLOT) % 4;
      f = gt / FRAME;
      hidden = (((f / BF) % 2) == 1) && (s == 0);
      e = OFF;
      if (c >= BLANK && en && !hidden) begin
        e.an   = tab[s].an;
        e.sseg = tab[s].dig;
        e.dp   = tab[s].dpb;
        if (s == 1) e.sseg = (f == 0) ? 7'b1111001 : (f == 1) ? 7'b0001100 : 7'b0010010;
      end
      tick();
      chk($sformatf("scan gt=%0d", gt), cur(), e);
    end

    // Mid-scan reset during digit 3, new values presented at release
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("midrst c%0d", i), cur(), OFF);
    end
    rst = 1'b0;
    dig0 = 7'b0001100; dig1 = 7'b0011001; dig2 = 7'b0000010; dig3 = 7'b1111000;
    dp_in = 4'b1111; blink = 4'b0000;

    rs[0] = '{lo: 0,  hi: 1,  o: OFF};
    rs[1] = '{lo: 2,  hi: 7,  o: '{an: 4'b1110, sseg: 7'b0001100, dp: 1'b1}};
    rs[2] = '{lo: 8,  hi: 9,  o: OFF};
    rs[3] = '{lo: 10, hi: 15, o: '{an: 4'b1101, sseg: 7'b0011001, dp: 1'b1}};
    for (int r = 0; r < 16; r++) begin
      if (r == 1) dig0 = 7'b1000000;
      tick();
      for (int k = 0; k < 4; k++)
        if (r >= rs[k].lo && r <= rs[k].hi)
          chk($sformatf("after_rst r=%0d", r), cur(), rs[k].o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sseg_scan.md
Name: sseg_scan

Overview:
- Time-multiplexed driver for the 4-digit common-anode 7-segment display.
- Sits directly downstream of the per-digit BCD/score-to-segment converters: it takes their active-low segment codes and drives the shared segment bus and the per-digit anodes.
- Inserts a blanking gap between digits to suppress ghosting.
- Latches a coherent snapshot of all digits once per frame.
- Supports per-digit blinking (e.g. the winner's 'P' or a flashing score).

Parameters:
- SLOT_CYC, 100000, clock cycles per digit slot (1 kHz slot at 100 MHz); must be >= 2.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be < SLOT_CYC.
- BLINK_FRAMES, 128, full 4-digit frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 blanks the outputs while the counters keep running
- dig0  in  7  segment code for digit 0 (rightmost), gfedcba, active low
- dig1  in  7  segment code for digit 1
- dig2  in  7  segment code for digit 2
- dig3  in  7  segment code for digit 3 (leftmost)
- dp_in  in  4  decimal points, bit k = digit k, active low
- blink  in  4  blink mask, bit k=1 makes digit k blink
- an  out  4  anode selects, active low, at most one bit low
- sseg  out  7  segment bus gfedcba, active low
- dp  out  1  decimal point, active low

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values, applied at the first clk edge with rst=1 and held while rst=1:
  - Outputs: an=4'b1111, sseg=7'b1111111, dp=1.
  - slot counter cnt=0, digit index idx=0, frame counter=0, blink phase=visible.
  - Shadow digits all 7'b1111111, shadow dp all 1, shadow blink all 0.
- Slot counter: cnt runs 0..SLOT_CYC-1. When cnt==SLOT_CYC-1, cnt goes to 0 and idx goes to (idx+1) mod 4 (wraps 3->0).
- Frame snapshot: when cnt==0 and idx==0, the shadow registers load dig0..dig3, dp_in and blink.
  - This includes the first cycle after reset release.
  - Input changes at any other time have no effect until the next snapshot.
- Blink: on each 3->0 idx wrap the frame counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Output selection is computed from the current cnt/idx, and the outputs are registered (1-cycle latency):
  - If cnt < BLANK_CYC, or en==0, or (shadow blink[idx]==1 and phase==hidden): next outputs are an=1111, sseg=1111111, dp=1.
  - Otherwise: an has only bit idx low, sseg=shadow dig[idx], dp=shadow dp[idx].
- Per-slot timing: digit k is lit on the pins for SLOT_CYC-BLANK_CYC cycles, starting one cycle after cnt reaches BLANK_CYC. Frame length is 4*SLOT_CYC cycles.
- en:
  - Deasserting en blanks the pins on the next edge; cnt, idx, snapshot and blink timing are unaffected.
  - Reasserting en resumes with the current slot, lighting on the next edge if cnt >= BLANK_CYC.
- Reset mid-operation: blank on the next edge and restart at digit 0. The snapshot is reloaded in the first cycle after release.
- Invariant: an never has more than one low bit, including across slot boundaries, because of the blanking gap.

Decomposition:
- Shared package (sseg_pkg):
  - SSEG_BLANK=7'b1111111, AN_OFF=4'b1111, N_DIGITS=4.
  - The SSEG_* glyph constants, shared with the converter.
- Optional sub-module sseg_scan_timer: holds cnt, idx, frame counter and blink phase. It outputs idx, in_blank, snapshot strobe and phase. The top level holds the shadow registers and output mux.

Test Plan:
All tests use SLOT_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset: hold rst 3 cycles with random inputs -> an=1111, sseg=1111111, dp=1 throughout. Cycles 1-2 after release stay blank.
2. Scan: dig0=7'b1000000, dig1=7'b1111001, dig2=7'b0100100, dig3=7'b0110000, dp_in=4'b1110, en=1 ->
   - Each slot is 2 blank cycles then 6 lit cycles.
   - an goes 1110, 1101, 1011, 0111 with the matching sseg.
   - dp=0 only while digit 0 is lit.
   - Frame length is 32 cycles.
3. Snapshot coherence: change dig1 to 7'b0001100 while digit 2 is lit -> digit 1 keeps showing 7'b1111001 until the next frame; from then on it shows 7'b0001100.
4. Blink: blink=4'b0001 -> digit 0 is lit in frames 0-1, blank (an=1111) in frames 2-3, lit in frames 4-5. Digits 1-3 are unaffected.
5. Enable: drop en at cnt=4 of digit 2 -> blank next cycle. Raise en 20 cycles later -> the scan position matches an uninterrupted run.
6. Mid-scan reset: assert rst during digit 3 -> blank next edge. After release, digit 0 is lit from the 3rd cycle, showing the values present at release.
